// File: rtl/shift_engine.sv
// Full-duplex serial/parallel shift engine with a frame FSM and an rxData/rxValid/rxAck holding register.
// Optional sticky overrun detection is enabled by defining SHIFT_ENGINE_OVERRUN_EN.
module shift_engine #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sampleEdge,
  input  logic             shiftEdge,
  input  logic             start,
  input  logic             lsbFirst,
  input  logic [width-1:0] parallelDataIn,
  input  logic             serialDataIn,
  input  logic             rxAck,
  output logic             serialDataOut,
  output logic [width-1:0] parallelDataOut,
  output logic [width-1:0] rxData,
  output logic             rxValid,
  output logic             rxOverrun,
  output logic             busy,
  output logic             frameDone
);

  localparam int CNT_W = $clog2(width + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           stateNext;
  logic [width-1:0] shiftReg;
  logic [width-1:0] shiftNext;
  logic [CNT_W-1:0] bitCnt;
  logic             sampleBit;
  logic             pending;
  logic             lsbLatched;
  logic             doLoad;
  logic             doShift;
  logic             doComplete;

  function automatic logic [width-1:0] shiftIn(input logic [width-1:0] v,
                                               input logic lsb,
                                               input logic b);
    return lsb ? {b, v[width-1:1]} : {v[width-2:0], b};
  endfunction

  assign shiftNext       = shiftIn(shiftReg, lsbLatched, sampleBit);
  assign parallelDataOut = shiftReg;
  assign serialDataOut   = lsbLatched ? shiftReg[0] : shiftReg[width-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    doLoad     = 1'b0;
    doShift    = 1'b0;
    doComplete = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          doLoad    = 1'b1;
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        // A shift edge only counts once a bit has been sampled for it.
        if (shiftEdge && pending) begin
          doShift = 1'b1;
          if (bitCnt == LAST_BIT) begin
            doComplete = 1'b1;
            stateNext  = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Shift datapath: load on start, then sample/shift while framing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shiftReg   <= '0;
      bitCnt     <= '0;
      sampleBit  <= 1'b0;
      pending    <= 1'b0;
      lsbLatched <= 1'b0;
    end else if (doLoad) begin
      shiftReg   <= parallelDataIn;
      lsbLatched <= lsbFirst;
      bitCnt     <= '0;
      pending    <= 1'b0;
    end else if (state == SHIFT) begin
      if (doShift) begin
        shiftReg <= shiftNext;
        bitCnt   <= bitCnt + CNT_W'(1);
      end
      // A coincident sample re-arms pending after the shift consumed the old bit.
      if (sampleEdge) begin
        sampleBit <= serialDataIn;
        pending   <= 1'b1;
      end else if (doShift) begin
        pending <= 1'b0;
      end
    end
  end

  // Receive holding register; a completion write beats a coincident ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxData    <= '0;
      rxValid   <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      frameDone <= doComplete;
      if (doComplete) begin
        rxData  <= shiftNext;
        rxValid <= 1'b1;
      end else if (rxAck) begin
        rxValid <= 1'b0;
      end
    end
  end

`ifdef SHIFT_ENGINE_OVERRUN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           rxOverrun <= 1'b0;
    else if (doComplete && rxValid && !rxAck) rxOverrun <= 1'b1;
    else if (rxAck)                         rxOverrun <= 1'b0;
  end
`else
  assign rxOverrun = 1'b0;
`endif

endmodule

// File: tb/tb_shift_engine.sv
// Scoreboard bench for shift_engine: stimulus pushes expected received words, a
// negedge monitor pops and checks them on every frameDone pulse.
module tb_shift_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sampleEdge, shiftEdge, start, lsbFirst, serialDataIn, rxAck;
  logic [7:0] parallelDataIn;
  logic       serialDataOut;
  logic [7:0] parallelDataOut, rxData;
  logic       rxValid, rxOverrun, busy, frameDone;

`ifdef SHIFT_ENGINE_OVERRUN_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       ovr;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  shift_engine #(.width(8)) dut (
    .clk(clk), .reset_n(reset_n), .sampleEdge(sampleEdge), .shiftEdge(shiftEdge),
    .start(start), .lsbFirst(lsbFirst), .parallelDataIn(parallelDataIn),
    .serialDataIn(serialDataIn), .rxAck(rxAck), .serialDataOut(serialDataOut),
    .parallelDataOut(parallelDataOut), .rxData(rxData), .rxValid(rxValid),
    .rxOverrun(rxOverrun), .busy(busy), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every frameDone pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (frameDone === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame.unexpected: got frameDone=1 expected no frame (t=%0t)", $time);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        chk("frame.rxData", 32'(rxData), 32'(e.data));
        chk("frame.rxValid", 32'(rxValid), 32'd1);
        chk("frame.rxOverrun", 32'(rxOverrun), 32'(e.ovr));
        chk("frame.busy", 32'(busy), 32'd0);
      end
    end
  end

  task automatic startFrame(input logic [7:0] tx, input logic lsb);
    parallelDataIn = tx;
    lsbFirst       = lsb;
    start          = 1'b1;
    @(posedge clk); #1;
    start          = 1'b0;
    lsbFirst       = ~lsb;      // must have been latched
    parallelDataIn = ~tx;
    chk("start.busy", 32'(busy), 32'd1);
  endtask

  task automatic sendBits(input logic [7:0] tx, input logic [7:0] rx, input logic lsb,
                          input int from, input int to, input logic ovrExp,
                          input logic ackLast);
    for (int k = from; k <= to; k++) begin
      int idx;
      idx = lsb ? k : 7 - k;
      chk($sformatf("sdo.bit%0d", k), 32'(serialDataOut), 32'(tx[idx]));
      sampleEdge   = 1'b1;
      serialDataIn = rx[idx];
      @(posedge clk); #1;
      sampleEdge = 1'b0;
      shiftEdge  = 1'b1;
      if (k == 7) begin
        expQ.push_back('{data: rx, ovr: ovrExp});
        rxAck = ackLast;
      end
      @(posedge clk); #1;
      shiftEdge = 1'b0;
      rxAck     = 1'b0;
    end
    if (to == 7) begin
      chk("done.busy", 32'(busy), 32'd0);
      chk("done.rxData", 32'(rxData), 32'(rx));
      chk("done.rxValid", 32'(rxValid), 32'd1);
    end
  endtask

  task automatic ackRx();
    rxAck = 1'b1;
    @(posedge clk); #1;
    rxAck = 1'b0;
    chk("ack.rxValid", 32'(rxValid), 32'd0);
    chk("ack.rxOverrun", 32'(rxOverrun), 32'd0);
  endtask

  task automatic chkIdleZero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".frameDone"}, 32'(frameDone), 32'd0);
    chk({tag, ".rxValid"}, 32'(rxValid), 32'd0);
    chk({tag, ".rxOverrun"}, 32'(rxOverrun), 32'd0);
    chk({tag, ".sdo"}, 32'(serialDataOut), 32'd0);
    chk({tag, ".pdo"}, 32'(parallelDataOut), 32'd0);
    chk({tag, ".rxData"}, 32'(rxData), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; sampleEdge = 1'b0; shiftEdge = 1'b0; start = 1'b0;
    lsbFirst = 1'b0; serialDataIn = 1'b0; rxAck = 1'b0; parallelDataIn = 8'h00;
    #3;
    chkIdleZero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // MSB-first: transmit A5 (1,0,1,0,0,1,0,1), receive 3C
    startFrame(8'hA5, 1'b0);
    sendBits(8'hA5, 8'h3C, 1'b0, 0, 7, 1'b0, 1'b0);
    ackRx();

    // LSB-first: transmit C1 (1,0,0,0,0,0,1,1), receive 81
    startFrame(8'hC1, 1'b1);
    sendBits(8'hC1, 8'h81, 1'b1, 0, 7, 1'b0, 1'b0);
    ackRx();

    // Stray shift edges and a mid-frame start are ignored
    startFrame(8'h5A, 1'b0);
    sendBits(8'h5A, 8'h96, 1'b0, 0, 2, 1'b0, 1'b0);
    chk("stray.pdoBefore", 32'(parallelDataOut), 32'hD4);
    for (int i = 0; i < 2; i++) begin
      shiftEdge = 1'b1;
      @(posedge clk); #1;
      shiftEdge = 1'b0;
      @(posedge clk); #1;
    end
    chk("stray.pdo", 32'(parallelDataOut), 32'hD4);
    chk("stray.sdo", 32'(serialDataOut), 32'd1);
    parallelDataIn = 8'hFF;
    start          = 1'b1;
    @(posedge clk); #1;
    start          = 1'b0;
    chk("midStart.pdo", 32'(parallelDataOut), 32'hD4);
    chk("midStart.busy", 32'(busy), 32'd1);
    sendBits(8'h5A, 8'h96, 1'b0, 3, 7, 1'b0, 1'b0);
    ackRx();

    // Reset mid-frame: immediate clear, no frameDone, then a clean frame
    startFrame(8'hA5, 1'b0);
    sendBits(8'hA5, 8'h3C, 1'b0, 0, 2, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chkIdleZero("midReset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    startFrame(8'h0F, 1'b0);
    sendBits(8'h0F, 8'hF0, 1'b0, 0, 7, 1'b0, 1'b0);

    // Second frame without ack: overrun when enabled, rxData overwritten
    startFrame(8'h33, 1'b0);
    sendBits(8'h33, 8'h5C, 1'b0, 0, 7, OVR, 1'b0);
    chk("overrun.flag", 32'(rxOverrun), 32'(OVR));
    ackRx();

    // Back-to-back frames; ack coinciding with the second completion loses
    startFrame(8'h81, 1'b0);
    sendBits(8'h81, 8'h42, 1'b0, 0, 7, 1'b0, 1'b0);
    startFrame(8'h7E, 1'b1);
    sendBits(8'h7E, 8'hA7, 1'b1, 0, 7, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("b2b.rxValidHeld", 32'(rxValid), 32'd1);
    chk("b2b.rxData", 32'(rxData), 32'hA7);
    ackRx();

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard.empty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
